// File: rtl/hamming_decoder.sv
// ============================================================================
// hamming_decoder : (8,4) SECDED decoder, 2-stage valid/ready pipeline
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module hamming_decoder #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_codeword,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_data,
   output logic             out_err_single,
   output logic             out_err_double,
   output logic [2:0]       out_syndrome,
   input  logic             clr_counts,
   output logic [CNT_W-1:0] single_count,
   output logic [CNT_W-1:0] double_count
);

   localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             s1_valid_q, s1_valid_d;
   logic [7:0]       s1_cw_q, s1_cw_d;
   logic             s2_valid_q, s2_valid_d;
   logic [3:0]       s2_data_q, s2_data_d;
   logic             s2_single_q, s2_single_d;
   logic             s2_double_q, s2_double_d;
   logic [2:0]       s2_syn_q, s2_syn_d;
   logic [CNT_W-1:0] single_cnt_q, single_cnt_d;
   logic [CNT_W-1:0] double_cnt_q, double_cnt_d;

   logic             w_s2_ready;
   logic             w_out_fire;
   logic [2:0]       w_syn;
   logic             w_par;
   logic [7:0]       w_fixed;

   assign w_s2_ready = !s2_valid_q || out_ready;
   assign in_ready   = !s1_valid_q || w_s2_ready;
   assign w_out_fire = s2_valid_q && out_ready;

   // Syndrome/parity of the word currently sitting in S1
   always_comb begin
      w_syn[0] = s1_cw_q[0] ^ s1_cw_q[2] ^ s1_cw_q[4] ^ s1_cw_q[6];
      w_syn[1] = s1_cw_q[1] ^ s1_cw_q[2] ^ s1_cw_q[5] ^ s1_cw_q[6];
      w_syn[2] = s1_cw_q[3] ^ s1_cw_q[4] ^ s1_cw_q[5] ^ s1_cw_q[6];
      w_par    = ^s1_cw_q;
      w_fixed  = s1_cw_q;
      // Only a single error (odd overall parity) at a Hamming position is flipped
      if ((w_syn != 3'd0) && w_par) begin
         w_fixed[w_syn - 3'd1] = ~s1_cw_q[w_syn - 3'd1];
      end
   end

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_cw_d     = s1_cw_q;
      s2_valid_d  = s2_valid_q;
      s2_data_d   = s2_data_q;
      s2_single_d = s2_single_q;
      s2_double_d = s2_double_q;
      s2_syn_d    = s2_syn_q;

      if (in_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_cw_d = in_codeword;
         end
      end

      if (w_s2_ready) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_data_d   = {w_fixed[6], w_fixed[5], w_fixed[4], w_fixed[2]};
            s2_single_d = w_par;
            s2_double_d = (w_syn != 3'd0) && !w_par;
            s2_syn_d    = w_syn;
         end
      end
   end

   // Counters advance only when a flagged result is actually delivered
   always_comb begin
      single_cnt_d = single_cnt_q;
      double_cnt_d = double_cnt_q;
      if (clr_counts) begin
         single_cnt_d = '0;
         double_cnt_d = '0;
      end else if (w_out_fire) begin
         if (s2_single_q && (single_cnt_q != C_CNT_MAX)) begin
            single_cnt_d = single_cnt_q + C_CNT_ONE;
         end
         if (s2_double_q && (double_cnt_q != C_CNT_MAX)) begin
            double_cnt_d = double_cnt_q + C_CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_cw_q      <= 8'h00;
         s2_valid_q   <= 1'b0;
         s2_data_q    <= 4'h0;
         s2_single_q  <= 1'b0;
         s2_double_q  <= 1'b0;
         s2_syn_q     <= 3'd0;
         single_cnt_q <= '0;
         double_cnt_q <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_cw_q      <= s1_cw_d;
         s2_valid_q   <= s2_valid_d;
         s2_data_q    <= s2_data_d;
         s2_single_q  <= s2_single_d;
         s2_double_q  <= s2_double_d;
         s2_syn_q     <= s2_syn_d;
         single_cnt_q <= single_cnt_d;
         double_cnt_q <= double_cnt_d;
      end
   end

   assign out_valid      = s2_valid_q;
   assign out_data       = s2_data_q;
   assign out_err_single = s2_single_q;
   assign out_err_double = s2_double_q;
   assign out_syndrome   = s2_syn_q;
   assign single_count   = single_cnt_q;
   assign double_count   = double_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hamming_decoder.sv
// ============================================================================
// tb_hamming_decoder : directed self-checking bench for hamming_decoder
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_hamming_decoder;

   localparam int CNT_W = 2;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_codeword;
   logic             out_valid;
   logic             out_ready;
   logic [3:0]       out_data;
   logic             out_err_single;
   logic             out_err_double;
   logic [2:0]       out_syndrome;
   logic             clr_counts;
   logic [CNT_W-1:0] single_count;
   logic [CNT_W-1:0] double_count;

   int checks;
   int failures;

   hamming_decoder #(.CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_codeword    (in_codeword),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_err_single (out_err_single),
      .out_err_double (out_err_double),
      .out_syndrome   (out_syndrome),
      .clr_counts     (clr_counts),
      .single_count   (single_count),
      .double_count   (double_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [3:0] d, input logic [2:0] s,
                          input logic es, input logic ed);
      chk({tag, "_valid"},  32'(out_valid), 32'd1);
      chk({tag, "_data"},   32'(out_data), 32'(d));
      chk({tag, "_syn"},    32'(out_syndrome), 32'(s));
      chk({tag, "_single"}, 32'(out_err_single), 32'(es));
      chk({tag, "_double"}, 32'(out_err_double), 32'(ed));
   endtask

   // Present one word for one edge then drop in_valid; leaves time at edge+1
   task automatic send(input logic [7:0] cw);
      in_valid    = 1'b1;
      in_codeword = cw;
      step();
      in_valid    = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      checks      = 0;
      failures    = 0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_codeword = 8'h00;
      out_ready   = 1'b1;
      clr_counts  = 1'b0;
      step();
      step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready), 32'd1);
      chk("rst_data",      32'(out_data), 32'd0);
      chk("rst_single_ct", 32'(single_count), 32'd0);
      chk("rst_double_ct", 32'(double_count), 32'd0);
      rst_n = 1'b1;
      step();

      // T1 clean word, two-cycle latency
      send(8'h55);
      chk("t1_lat_early", 32'(out_valid), 32'd0);
      step();
      chk_out("t1", 4'hB, 3'd0, 1'b0, 1'b0);
      step();
      chk("t1_drained", 32'(out_valid), 32'd0);

      // T2 single error at position 5
      send(8'h45);
      step();
      chk_out("t2", 4'hB, 3'd5, 1'b1, 1'b0);
      chk("t2_cnt_pre", 32'(single_count), 32'd0);
      step();
      chk("t2_cnt", 32'(single_count), 32'd1);

      // T3 overall-parity error then double error
      send(8'hD5);
      send(8'h56);
      chk_out("t3a", 4'hB, 3'd0, 1'b1, 1'b0);
      step();
      chk_out("t3b", 4'hB, 3'd3, 1'b0, 1'b1);
      chk("t3_single_ct", 32'(single_count), 32'd2);
      step();
      chk("t3_double_ct", 32'(double_count), 32'd1);
      chk("t3_drained", 32'(out_valid), 32'd0);

      // T4 backpressure
      out_ready   = 1'b0;
      in_valid    = 1'b1;
      in_codeword = 8'h00;
      step();
      in_codeword = 8'h55;
      #1;
      chk("t4_ready_w2", 32'(in_ready), 32'd1);
      step();
      in_codeword = 8'h45;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t4_stall_ready", 32'(in_ready), 32'd0);
         chk("t4_stall_data",  32'(out_data), 32'h0);
         chk("t4_stall_valid", 32'(out_valid), 32'd1);
         step();
      end
      out_ready = 1'b1;
      #1;
      chk("t4_release_ready", 32'(in_ready), 32'd1);
      chk_out("t4w0", 4'h0, 3'd0, 1'b0, 1'b0);
      step();
      in_valid = 1'b0;
      chk_out("t4w1", 4'hB, 3'd0, 1'b0, 1'b0);
      step();
      chk_out("t4w2", 4'hB, 3'd5, 1'b1, 1'b0);
      step();
      chk("t4_drained", 32'(out_valid), 32'd0);
      chk("t4_single_ct", 32'(single_count), 32'd3);

      // T5 clear, saturation, clear beating a coincident increment
      clr_counts = 1'b1;
      step();
      clr_counts = 1'b0;
      chk("t5_clr_single", 32'(single_count), 32'd0);
      chk("t5_clr_double", 32'(double_count), 32'd0);
      in_valid    = 1'b1;
      in_codeword = 8'h45;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t5_stream_ready", 32'(in_ready), 32'd1);
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      chk("t5_saturated", 32'(single_count), 32'd3);
      chk("t5_drained", 32'(out_valid), 32'd0);
      send(8'h45);
      step();
      chk("t5_sixth_valid", 32'(out_valid), 32'd1);
      clr_counts = 1'b1;
      step();
      clr_counts = 1'b0;
      chk("t5_clr_wins", 32'(single_count), 32'd0);

      // T6 asynchronous reset with both stages full
      send(8'h56);
      step();
      step();
      chk("t6_pre_double", 32'(double_count), 32'd1);
      out_ready = 1'b0;
      send(8'h55);
      send(8'h45);
      chk("t6_full_ready", 32'(in_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid",  32'(out_valid), 32'd0);
      chk("t6_rst_double", 32'(double_count), 32'd0);
      chk("t6_rst_data",   32'(out_data), 32'd0);
      step();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("t6_post_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t6_no_ghost", 32'(out_valid), 32'd0);
      end
      chk("t6_post_single", 32'(single_count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
